// File: rtl/int_service_if.sv
// Bundle between the interrupt controller/core and the interrupt service unit.
// The master side drives pending sources and core events; the slave side issues the vectored call.
interface int_service_if;
  logic [4:0]  interupt;
  logic [4:0]  IP;
  logic        instr_end;
  logic        blk_wr;
  logic        reti;
  logic        int_ack;
  logic        int_req;
  logic [15:0] int_vector;
  logic [3:0]  clr_flag;
  logic [1:0]  in_service;

  modport master (
    output interupt, IP, instr_end, blk_wr, reti, int_ack,
    input  int_req, int_vector, clr_flag, in_service
  );

  modport slave (
    input  interupt, IP, instr_end, blk_wr, reti, int_ack,
    output int_req, int_vector, clr_flag, in_service
  );
endinterface

// File: rtl/int_service.sv
// Interrupt service unit: samples pending sources at instruction boundaries and issues vectored calls.
// Define INT_NEST_EN for two priority levels with nesting; otherwise a single level, IP ignored.
module int_service #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int          VEC_STRIDE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  int_service_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t      state, state_nxt;
  logic        blk_flag, blk_flag_nxt;
  logic [1:0]  in_svc, in_svc_nxt, in_svc_eff;
  logic        req_q, req_nxt;
  logic [15:0] vec_q, vec_nxt;
  logic [3:0]  clr_q, clr_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        lvl, lvl_nxt;
  logic [4:0]  hi_elig, lo_elig;
  logic        found, sel_lvl, blocked;
  logic [2:0]  sel_idx;

  // RETI retires the innermost level first, and eligibility sees the retired state.
`ifdef INT_NEST_EN
  always_comb begin
    in_svc_eff = in_svc;
    if (bus.reti) begin
      if (in_svc[1]) in_svc_eff[1] = 1'b0;
      else           in_svc_eff[0] = 1'b0;
    end
    hi_elig = in_svc_eff[1]    ? 5'b0 : (bus.interupt & bus.IP);
    lo_elig = (|in_svc_eff)    ? 5'b0 : (bus.interupt & ~bus.IP);
  end
`else
  logic unused_ip;
  assign unused_ip = ^bus.IP;

  always_comb begin
    in_svc_eff = {1'b0, bus.reti ? 1'b0 : in_svc[0]};
    hi_elig    = 5'b0;
    lo_elig    = (|in_svc_eff) ? 5'b0 : bus.interupt;
  end
`endif

  // Descending scans so the lowest bit wins; the high-level scan runs last and overrides.
  always_comb begin
    found   = 1'b0;
    sel_idx = 3'd0;
    sel_lvl = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (lo_elig[i]) begin
        found   = 1'b1;
        sel_idx = 3'(i);
      end
    end
    for (int i = 4; i >= 0; i--) begin
      if (hi_elig[i]) begin
        found   = 1'b1;
        sel_idx = 3'(i);
        sel_lvl = 1'b1;
      end
    end
  end

  assign blocked      = blk_flag | bus.reti | bus.blk_wr;
  assign blk_flag_nxt = bus.instr_end ? 1'b0 : (blk_flag | bus.reti | bus.blk_wr);

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    vec_nxt    = vec_q;
    clr_nxt    = 4'b0000;
    idx_nxt    = idx;
    lvl_nxt    = lvl;
    in_svc_nxt = in_svc_eff;
    case (state)
      IDLE: begin
        if (bus.instr_end && !blocked && found) begin
          req_nxt   = 1'b1;
          vec_nxt   = VEC_BASE + 16'(sel_idx) * 16'(VEC_STRIDE);
          idx_nxt   = sel_idx;
          lvl_nxt   = sel_lvl;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          req_nxt         = 1'b0;
          clr_nxt         = (idx == 3'd4) ? 4'b0000 : (4'b0001 << idx[1:0]);
          in_svc_nxt[lvl] = 1'b1;
          state_nxt       = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk_flag <= 1'b0;
      in_svc   <= 2'b00;
      req_q    <= 1'b0;
      vec_q    <= 16'h0000;
      clr_q    <= 4'b0000;
      idx      <= 3'd0;
      lvl      <= 1'b0;
    end else begin
      state    <= state_nxt;
      blk_flag <= blk_flag_nxt;
      in_svc   <= in_svc_nxt;
      req_q    <= req_nxt;
      vec_q    <= vec_nxt;
      clr_q    <= clr_nxt;
      idx      <= idx_nxt;
      lvl      <= lvl_nxt;
    end
  end

  assign bus.int_req    = req_q;
  assign bus.int_vector = vec_q;
  assign bus.clr_flag   = clr_q;
  assign bus.in_service = in_svc;

endmodule

// File: tb/tb_int_service.sv
// Directed bench for int_service; expected vectors are queued at stimulus time and popped on request.
module tb_int_service;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  logic [15:0] exp_q[$];

  int_service_if bus ();

  int_service dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse of the chosen core events.
  task automatic applyStimulus(input logic ie, input logic rt, input logic bw, input logic ack);
    bus.instr_end = ie;
    bus.reti      = rt;
    bus.blk_wr    = bw;
    bus.int_ack   = ack;
    tick();
    bus.instr_end = 1'b0;
    bus.reti      = 1'b0;
    bus.blk_wr    = 1'b0;
    bus.int_ack   = 1'b0;
  endtask

  task automatic expectReq(input string tag);
    logic [15:0] e;
    checkOutput({tag, "_req"}, 16'(bus.int_req), 16'h0001);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue"}, 16'(exp_q.size()), 16'h0001);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_vec"}, bus.int_vector, e);
    end
  endtask

  task automatic expectNoReq(input string tag);
    checkOutput(tag, 16'(bus.int_req), 16'h0000);
  endtask

  task automatic ackAndCheck(input string tag, input logic [3:0] clr, input logic [1:0] svc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_clr"}, 16'(bus.clr_flag), 16'(clr));
    checkOutput({tag, "_svc"}, 16'(bus.in_service), 16'(svc));
    checkOutput({tag, "_reqfall"}, 16'(bus.int_req), 16'h0000);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.interupt  = 5'b0;
    bus.IP        = 5'b0;
    bus.instr_end = 1'b0;
    bus.blk_wr    = 1'b0;
    bus.reti      = 1'b0;
    bus.int_ack   = 1'b0;
    tick();
    tick();
    checkOutput("rst_req", 16'(bus.int_req), 16'h0000);
    checkOutput("rst_vec", bus.int_vector, 16'h0000);
    checkOutput("rst_clr", 16'(bus.clr_flag), 16'h0000);
    checkOutput("rst_svc", 16'(bus.in_service), 16'h0000);
    rst_n = 1'b1;
    tick();

    // T0 and T1 pending at low level: T0 wins.
    bus.interupt = 5'b01010;
    exp_q.push_back(16'h000B);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("t0");
    bus.interupt = 5'b00000;
    tick();
    checkOutput("t0_hold_req", 16'(bus.int_req), 16'h0001);
    checkOutput("t0_hold_vec", bus.int_vector, 16'h000B);
    ackAndCheck("t0_ack", 4'b0010, 2'b01);
    tick();
    checkOutput("t0_clr_pulse", 16'(bus.clr_flag), 16'h0000);

    // INT1 at high priority while the low T0 handler runs.
    bus.interupt = 5'b00100;
    bus.IP       = 5'b00100;
`ifdef INT_NEST_EN
    exp_q.push_back(16'h0013);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("nest");
    ackAndCheck("nest_ack", 4'b0100, 2'b11);
    bus.interupt = 5'b00001;
    bus.IP       = 5'b00001;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectNoReq("hi_busy");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reti_hi_svc", 16'(bus.in_service), 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectNoReq("reti_block");
    exp_q.push_back(16'h0003);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("int0_hi");
    ackAndCheck("int0_ack", 4'b0001, 2'b11);
    bus.interupt = 5'b00000;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reti1_svc", 16'(bus.in_service), 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reti2_svc", 16'(bus.in_service), 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
`else
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectNoReq("nonest_busy");
    tick();
    expectNoReq("nonest_busy2");
    bus.interupt = 5'b00000;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reti_svc", 16'(bus.in_service), 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
`endif
    bus.IP = 5'b00000;

    // Serial source: vector 0023, no hardware flag clear.
    bus.interupt = 5'b10000;
    exp_q.push_back(16'h0023);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("serial");
    ackAndCheck("serial_ack", 4'b0000, 2'b01);
    bus.interupt = 5'b00000;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("serial_reti", 16'(bus.in_service), 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // IE/IP write in the same instruction defers sampling by one boundary.
    bus.interupt = 5'b01000;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectNoReq("blkwr_block");
    exp_q.push_back(16'h001B);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("t1");
    ackAndCheck("t1_ack", 4'b1000, 2'b01);
    bus.interupt = 5'b00000;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // RETI with nothing in service still blocks the next boundary.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reti_idle_svc", 16'(bus.in_service), 16'h0000);
    bus.interupt = 5'b01000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectNoReq("reti_idle_block");
    exp_q.push_back(16'h001B);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("t1_again");

    // Asynchronous reset in REQ, observed between clock edges.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_req", 16'(bus.int_req), 16'h0000);
    checkOutput("arst_vec", bus.int_vector, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset right after an ack clears the flag pulse and service level.
    exp_q.push_back(16'h001B);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectReq("t1_post_rst");
    ackAndCheck("t1_post_ack", 4'b1000, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_clr", 16'(bus.clr_flag), 16'h0000);
    checkOutput("arst_svc", 16'(bus.in_service), 16'h0000);
    bus.interupt = 5'b00000;
    tick();
    rst_n = 1'b1;
    tick();

    checkOutput("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/int_service.md
# int_service

Interrupt service unit; the CPU-side responder to the interrupt controller's pending-source vector. It samples pending requests at instruction boundaries and applies the IP priority levels and in-service nesting rules. It then issues a vectored call request to the core and receives the acknowledge. It also reports which hardware-cleared flags to clear and tracks in-service levels until RETI.

## Interface
Parameters:
- `VEC_BASE`, 16'h0003: address of source 0 vector.
- `VEC_STRIDE`, 8: byte spacing between vectors.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `interupt`  in  5  pending sources from the interrupt controller. Bit 0 = INT0, bit 1 = T0, bit 2 = INT1, bit 3 = T1, bit 4 = serial. The controller has already gated these with IE and EA.
- `IP`  in  5  priority bits; 1 = high level.
- `instr_end`  in  1  one-cycle pulse: the core is at the last cycle of an instruction.
- `blk_wr`  in  1  pulse: the current instruction writes IE or IP.
- `reti`  in  1  pulse: the current instruction is RETI.
- `int_ack`  in  1  the core has pushed the PC and is taking the vector.
- `int_req`  out  1  vectored-call request to the core.
- `int_vector`  out  16  target address, valid while `int_req` = 1.
- `clr_flag`  out  4  one-cycle pulse to clear TCON flags {TF1, IE1, TF0, IE0}.
- `in_service`  out  2  {high active, low active}.

## Operation
- State machine: IDLE, REQ, ACK.
- IDLE:
  - On `instr_end`, when not blocked and an eligible source exists, latch the source index, raise `int_req`, drive `int_vector`, and go to REQ.
- Eligibility:
  - A source must be pending.
  - If it is low level: no level active.
  - If it is high level: high not active.
- Selection:
  - Highest eligible level wins.
  - Within a level, fixed order: bit 0 first, bit 4 last.
- `int_vector` = `VEC_BASE` + idx*`VEC_STRIDE`. With defaults: 0003, 000B, 0013, 001B, 0023.
- REQ:
  - Hold `int_req` and `int_vector` stable until `int_ack`.
  - On `int_ack`: set the in-service bit for the latched level.
  - Also on `int_ack`: pulse `clr_flag` for idx 0–3; idx 4 produces none, since serial RI/TI are cleared by software.
  - Then go to ACK.
- ACK: one cycle with `int_req` = 0, then back to IDLE. This guarantees at least one instruction of the ISR executes before the next request.
- Block rule: if `reti` or `blk_wr` was seen during the current instruction, the next `instr_end` is not a sampling point. The flag clears after that `instr_end`.
- RETI: clears the highest active in-service bit (high before low).
- Simultaneous events:
  - RETI in-service clear takes effect before eligibility at the same `instr_end`, but the block rule still suppresses that sample.
  - If `interupt` drops while in REQ, the request is held anyway; the core completes the call.
- Reset mid-operation (async): returns to IDLE immediately; all in-service bits and the block flag are cleared.

## Timing
- Reset values:
  - `int_req` = 0.
  - `int_vector` = 16'h0000.
  - `clr_flag` = 0.
  - `in_service` = 2'b00.
  - state = IDLE.
  - block flag = 0.
- All outputs are registered.
- `int_req` rises on the clock edge after the `instr_end` cycle (1-cycle latency).
- `int_ack` is sampled only in REQ; it is ignored elsewhere.
- `clr_flag` and the in-service set occur on the edge after the `int_ack` cycle; `int_req` falls on the same edge.
- Minimum spacing: from one `int_ack` to the next `int_req` is 2 cycles plus an `instr_end`.
- `reti` with no in-service bit set: no effect on `in_service`; the block flag is still set.

## Configuration
- `INT_NEST_EN` defined:
  - Two priority levels with nesting as above.
  - `in_service` has 2 meaningful bits.
- `INT_NEST_EN` undefined:
  - `IP` is ignored and all sources are low level.
  - Any active service blocks all requests.
  - `in_service[1]` is tied 0.
  - RETI clears `in_service[0]`.

## Test plan
- Pending 5'b01010 (T0, T1), IP = 0, `instr_end` pulse → next cycle `int_req` = 1, `int_vector` = 000B. After `int_ack`: `clr_flag` = 4'b0010, `in_service` = 01.
- Low ISR (T0) in service; INT1 pending with IP[2] = 1, then `instr_end` → `int_vector` = 0013, `in_service` = 11 after ack (nesting). With `INT_NEST_EN` undefined → no `int_req`.
- High in service; INT0 pending with IP[0] = 1 → no `int_req` until `reti`. After RETI, the first `instr_end` is blocked; the second gives `int_vector` = 0003.
- Serial pending only (5'b10000), IP = 0 → `int_vector` = 0023. After ack: `clr_flag` = 0000, `in_service` = 01.
- `blk_wr` in the same instruction as a pending T1 → no request at that `instr_end`; request with `int_vector` = 001B at the next `instr_end`.
- `rst_n` asserted while in REQ → `int_req`, `in_service`, and `clr_flag` go to 0 immediately, without waiting for `clk`.
